base_decode_skid: RTL and testbench
===================================

Name: base_decode_skid

Overview:
- Parametrised, pipelined successor to the combinational binary-to-one-hot decode cell.
- Accepts encoded indices on a valid/ready input and decodes each in one of three selectable modes: one-hot, thermometer or one-cold.
- Delivers results through a 2-entry skid buffer on a valid/ready output, and counts out-of-range requests.
- Sits between arbitration/steering logic and per-channel enable fanout where timing needs a registered decode with backpressure.

Parameters:
- enc_width, 3, width of encoded index input.
- dec_width, 2**enc_width, width of decoded output. Any value 1..2**enc_width is legal; indices >= dec_width are out of range.
- cnt_width, 8, width of the saturating out-of-range counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous reset, active low.
- i_v  in  1  input beat valid.
- i_r  out  1  input ready.
- i_d  in  enc_width  encoded index.
- i_mode  in  2  decode mode, sampled with the beat: 0 one-hot, 1 thermometer, 2 one-cold, 3 reserved.
- o_v  out  1  output beat valid.
- o_r  in  1  output ready.
- o_d  out  dec_width  decoded vector.
- o_err  out  1  beat was out of range or used a reserved mode; qualified by o_v.
- err_cnt  out  cnt_width  saturating count of accepted error beats.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - Skid buffer empties; o_v=0, o_d=0, o_err=0, err_cnt=0, i_r=0 during reset.
  - i_r=1 from the first cycle after rstn returns high.
  - Reset mid-transfer discards all buffered beats; nothing is replayed.
- Handshakes:
  - Input transfer occurs when i_v&i_r at a clk edge.
  - Output transfer occurs when o_v&o_r at a clk edge.
  - i_r is a registered signal, equal to (occupancy<2) as of the previous edge. It must not combinationally depend on o_r.
- Latency and throughput:
  - An accepted beat appears on o_d/o_err in the next cycle when the buffer was empty or is draining the same cycle.
  - With o_r held high, one beat per cycle is sustained indefinitely.
- Skid buffer:
  - 2 entries; o_d/o_err always present the oldest entry.
  - o_v=1 iff occupancy>0.
  - Once o_v rises, o_d/o_err hold stable until the transfer (o_v&o_r).
  - Order is strictly FIFO.
  - Simultaneous accept and drain leaves occupancy unchanged.
- Decode rules (for in-range idx=i_d<dec_width, bit k):
  - Mode 0: o_d[k] = (k==idx).
  - Mode 1: o_d[k] = (k<=idx), so idx=0 gives 1 bit set.
  - Mode 2: o_d[k] = (k!=idx).
- Out of range (i_d>=dec_width):
  - Mode 0 outputs all zeros; mode 1 outputs all ones (saturate); mode 2 outputs all ones.
  - o_err=1 for that beat.
- Mode 3:
  - Decoded as mode 0, with o_err=1 regardless of range.
- err_cnt:
  - Increments by 1 on every input transfer whose beat will carry o_err=1, counted at acceptance rather than delivery.
  - Saturates at 2**cnt_width-1.
  - err_clr=1 forces 0 at the next edge and takes priority over a same-cycle increment.
- Edge cases:
  - When dec_width==2**enc_width, out-of-range is impossible; only mode 3 raises o_err.
  - dec_width=1 is legal: every non-zero index is out of range.
  - i_d/i_mode are don't-care when i_v=0; an unaccepted beat never alters state.

Test Plan:
- Reset, then enc_width=3, dec_width=8, o_r=1; send i_d=5 in mode 0, then mode 1, then mode 2 on consecutive cycles -> o_d=8'h20, 8'h3F, 8'hDF on cycles 1,2,3 after each accept; o_err=0; i_r stays 1.
- dec_width=6: send i_d=6 in modes 0, 1 and 2 -> o_d=6'h00, 6'h3F, 6'h3F with o_err=1 each time; err_cnt=3.
- Backpressure: hold o_r=0 and present 3 beats (i_d=1,2,3, mode 0) -> i_r drops after 2 accepts and the third beat stalls. Then o_r=1 -> outputs 8'h02, 8'h04, 8'h08 in order, no loss or duplication, o_d stable while stalled.
- cnt_width=2: send 5 beats with mode 3 -> err_cnt reads 1,2,3,3,3. Assert err_clr in the same cycle as a 6th error accept -> err_cnt=0.
- Pull rstn low with 2 beats buffered and o_r=0 -> next cycle o_v=0, err_cnt=0, i_r=0. After rstn returns high, i_r=1 the following cycle and no stale beat appears.
- Random i_v/o_r/i_d/i_mode for 10k cycles against a reference queue model -> all outputs match, no ordering violations, throughput 1/cycle whenever o_r=1 continuously.

Source files
------------

// File: rtl/base_decode_skid.sv
// Registered binary decode (one-hot / thermometer / one-cold) behind a 2-entry skid buffer,
// with a saturating counter of accepted error beats.
module base_decode_skid #(
    parameter int unsigned enc_width = 3,
    parameter int unsigned dec_width = 2 ** enc_width,
    parameter int unsigned cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_v,
    output logic                 i_r,
    input  logic [enc_width-1:0] i_d,
    input  logic [1:0]           i_mode,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [dec_width-1:0] o_d,
    output logic                 o_err,
    output logic [cnt_width-1:0] err_cnt,
    input  logic                 err_clr
);

    int unsigned          idx;
    logic                 in_range;
    logic [dec_width-1:0] dec;
    logic                 dec_err;

    always_comb begin
        idx      = {{(32 - enc_width){1'b0}}, i_d};
        in_range = idx < dec_width;
        dec      = '0;
        // Out-of-range indices fall out naturally: no bit matches, every bit is below/unequal.
        for (int unsigned k = 0; k < dec_width; k++) begin
            case (i_mode)
                2'd1:    dec[k] = (k <= idx);
                2'd2:    dec[k] = (k != idx);
                default: dec[k] = (k == idx);
            endcase
        end
        dec_err = !in_range || (i_mode == 2'd3);
    end

    logic [dec_width:0]   head_q, head_d;
    logic [dec_width:0]   skid_q, skid_d;
    logic [1:0]           occ_q, occ_d;
    logic                 ir_q;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic                 push, pop;
    logic [dec_width:0]   beat;

    assign beat = {dec_err, dec};
    assign push = i_v & ir_q;
    assign pop  = (occ_q != 2'd0) & o_r;

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = beat;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = beat;
                end else if (push) begin
                    skid_d = beat;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                // Full: i_r is low, so only a drain can happen here.
                if (pop) begin
                    head_d = skid_q;
                    occ_d  = 2'd1;
                end
            end
        endcase

        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (push && dec_err && (cnt_q != {cnt_width{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q <= '0;
            skid_q <= '0;
            occ_q  <= 2'd0;
            ir_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
            ir_q   <= (occ_d != 2'd2);
            cnt_q  <= cnt_d;
        end
    end

    assign i_r     = ir_q;
    assign o_v     = (occ_q != 2'd0);
    assign o_d     = head_q[dec_width-1:0];
    assign o_err   = head_q[dec_width];
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_base_decode_skid.sv
// Bench for base_decode_skid: a full-range instance (8 outputs) and a narrow one (6 outputs,
// 2-bit counter) share stimulus, each checked against its own queue model.
module tb_base_decode_skid;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_v;
    logic [2:0] i_d;
    logic [1:0] i_mode;
    logic       o_r;
    logic       err_clr;

    logic       i_r_a, o_v_a, o_err_a;
    logic [7:0] o_d_a;
    logic [7:0] err_cnt_a;
    logic       i_r_b, o_v_b, o_err_b;
    logic [5:0] o_d_b;
    logic [1:0] err_cnt_b;

    always #5 clk = ~clk;

    base_decode_skid #(.enc_width(3), .dec_width(8), .cnt_width(8)) dut_a (
        .clk(clk), .rstn(rstn), .i_v(i_v), .i_r(i_r_a), .i_d(i_d), .i_mode(i_mode),
        .o_v(o_v_a), .o_r(o_r), .o_d(o_d_a), .o_err(o_err_a), .err_cnt(err_cnt_a),
        .err_clr(err_clr)
    );

    base_decode_skid #(.enc_width(3), .dec_width(6), .cnt_width(2)) dut_b (
        .clk(clk), .rstn(rstn), .i_v(i_v), .i_r(i_r_b), .i_d(i_d), .i_mode(i_mode),
        .o_v(o_v_b), .o_r(o_r), .o_d(o_d_b), .o_err(o_err_b), .err_cnt(err_cnt_b),
        .err_clr(err_clr)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int         na, nb;
    logic       exp_ir;
    logic       armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {err, decoded} from the decode rules, for an output of width dw.
    function automatic logic [8:0] model(input int idx, input int m, input int dw);
        logic [7:0] mask;
        logic [7:0] d;
        logic       oor;
        mask = 8'((1 << dw) - 1);
        oor  = idx >= dw;
        case (m)
            1:       d = oor ? mask : 8'((2 << idx) - 1);
            2:       d = oor ? mask : (mask & ~8'(1 << idx));
            default: d = oor ? 8'h00 : 8'(1 << idx);
        endcase
        return {oor || (m == 3), d & mask};
    endfunction

    // Called just after a falling edge: drive, check state left by the previous rising edge,
    // then advance the model to what the coming rising edge should produce.
    task automatic cycle(input logic v, input logic [2:0] d, input logic [1:0] m,
                         input logic ordy, input logic clr);
        logic       push, pop;
        logic [8:0] ea, eb;
        i_v = v; i_d = d; i_mode = m; o_r = ordy; err_clr = clr;
        #1;
        if (armed) begin
            check("i_r_a", {31'b0, i_r_a}, {31'b0, exp_ir});
            check("i_r_b", {31'b0, i_r_b}, {31'b0, exp_ir});
            check("o_v_a", {31'b0, o_v_a}, {31'b0, qa.size() > 0});
            check("o_v_b", {31'b0, o_v_b}, {31'b0, qb.size() > 0});
            if (qa.size() > 0) check("out_a", {23'b0, o_err_a, o_d_a}, {23'b0, qa[0]});
            if (qb.size() > 0) check("out_b", {23'b0, o_err_b, 2'b00, o_d_b}, {23'b0, qb[0]});
            check("cnt_a", {24'b0, err_cnt_a}, na);
            check("cnt_b", {30'b0, err_cnt_b}, nb);
        end
        if (!rstn) begin
            qa.delete();
            qb.delete();
            na     = 0;
            nb     = 0;
            exp_ir = 1'b0;
            armed  = 1'b1;
        end else begin
            pop  = (qa.size() > 0) && ordy;
            push = v && exp_ir;
            ea   = model(int'(d), int'(m), 8);
            eb   = model(int'(d), int'(m), 6);
            if (pop) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (push) begin
                qa.push_back(ea);
                qb.push_back(eb);
            end
            if (clr) na = 0;
            else if (push && ea[8] && na < 255) na++;
            if (clr) nb = 0;
            else if (push && eb[8] && nb < 3) nb++;
            exp_ir = qa.size() < 2;
        end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; i_v = 1'b0; i_d = '0; i_mode = '0; o_r = 1'b0; err_clr = 1'b0;
        @(negedge clk);

        // Reset and release.
        repeat (3) cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
        check("rst_od", {24'b0, o_d_a}, 32'h0);
        check("rst_ir", {31'b0, i_r_a}, 32'h0);
        rstn = 1'b1;
        cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
        check("ir_after_rst", {31'b0, i_r_a}, 32'h1);

        // idx 5 in modes 0,1,2: 0x20, 0x3F, 0xDF.
        cycle(1'b1, 3'd5, 2'd0, 1'b1, 1'b0);
        check("m0_lit", {23'b0, o_err_a, o_d_a}, 32'h020);
        cycle(1'b1, 3'd5, 2'd1, 1'b1, 1'b0);
        check("m1_lit", {23'b0, o_err_a, o_d_a}, 32'h03F);
        cycle(1'b1, 3'd5, 2'd2, 1'b1, 1'b0);
        check("m2_lit", {23'b0, o_err_a, o_d_a}, 32'h0DF);

        // idx 6 is out of range on the 6-wide instance.
        for (int m = 0; m < 3; m++) cycle(1'b1, 3'd6, 2'(m), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
        check("oor_cnt_b", {30'b0, err_cnt_b}, 32'd3);
        cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b1);

        // Backpressure: third beat stalls until the sink drains.
        cycle(1'b1, 3'd1, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 2'd0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 3'd3, 2'd0, 1'b0, 1'b0);
        check("bp_ir", {31'b0, i_r_a}, 32'h0);
        check("bp_head", {24'b0, o_d_a}, 32'h02);
        repeat (2) cycle(1'b1, 3'd3, 2'd0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);

        // Mode 3 saturates the 2-bit counter; clear wins over a same-cycle error accept.
        repeat (5) cycle(1'b1, 3'd2, 2'd3, 1'b1, 1'b0);
        cycle(1'b1, 3'd2, 2'd3, 1'b1, 1'b1);
        check("clr_cnt_b", {30'b0, err_cnt_b}, 32'd0);
        repeat (2) cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);

        // Reset with two beats buffered.
        cycle(1'b1, 3'd4, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 2'd3, 1'b0, 1'b0);
        rstn = 1'b0;
        cycle(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        check("mid_rst_ov", {31'b0, o_v_a}, 32'h0);
        check("mid_rst_cnt", {24'b0, err_cnt_a}, 32'h0);
        rstn = 1'b1;
        repeat (3) cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);

        // Random traffic, with stretches of continuous o_r.
        for (int c = 0; c < 10000; c++) begin
            logic ordy;
            ordy = ((c / 200) % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), ordy, 1'($urandom_range(0, 49) == 0));
        end
        o_r = 1'b1;
        repeat (3) cycle(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
